// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
// Two requesters share one bank of JK flag bits. A round-robin arbiter picks
// one command at a time. The command is applied in a single APPLY cycle, and
// the ack follows in the next cycle.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | sample a_valid/b_valid, grant one of them, latch its command
// APPLY  | update the latched bit, issue the ack, move the priority pointer
module jk_bank_arbiter #(
   parameter int N     = 8,
   parameter int IDX_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [IDX_W-1:0] a_idx,
   input  logic [1:0]       a_op,
   output logic             a_ack,
   input  logic             b_valid,
   input  logic [IDX_W-1:0] b_idx,
   input  logic [1:0]       b_op,
   output logic             b_ack,
   output logic [N-1:0]     q,
   output logic [N-1:0]     qb,
   output logic             busy,
   output logic             idx_err,
   output logic [CNT_W-1:0] cmd_count
);

   typedef enum logic {S_IDLE = 1'b0, S_APPLY = 1'b1} state_t;

   localparam logic [31:0] N_U = 32'(N);

   state_t           state;
   state_t           state_nx;
   logic             ptr;        // 0: A has priority on contention, 1: B
   logic             grant_a;
   logic             grant_b;
   logic [IDX_W-1:0] lat_idx;
   logic [1:0]       lat_op;
   logic             lat_id;     // 0: command came from A, 1: from B
   logic             in_range;
   logic [N-1:0]     sel;
   logic [N-1:0]     q_nx;

   // An out-of-range index shifts the single set bit off the top of sel, so
   // the bank update needs no separate range gating.
   assign sel      = N'(1) << lat_idx;
   assign in_range = (32'(lat_idx) < N_U);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: APPLY always lasts exactly one cycle
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (a_valid || b_valid) state_nx = S_APPLY;
         S_APPLY: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM outputs: busy flag and round-robin grant decision, evaluated only in IDLE
   always_comb begin
      busy    = (state == S_APPLY);
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == S_IDLE) begin
         if (a_valid && (!b_valid || !ptr)) grant_a = 1'b1;
         else if (b_valid)                  grant_b = 1'b1;
      end
   end

   // Next bank value for the latched JK op; unchanged outside APPLY
   always_comb begin
      q_nx = q;
      if (state == S_APPLY) begin
         case (lat_op)
            2'b01:   q_nx = q & ~sel;
            2'b10:   q_nx = q | sel;
            2'b11:   q_nx = q ^ sel;
            default: q_nx = q;
         endcase
      end
   end

   // Command latch, bank/complement registers, acks, error flag, counter, pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_idx   <= '0;
         lat_op    <= 2'b00;
         lat_id    <= 1'b0;
         ptr       <= 1'b0;
         q         <= '0;
         qb        <= '1;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         idx_err   <= 1'b0;
         cmd_count <= '0;
      end else begin
         q       <= q_nx;
         qb      <= ~q_nx;
         a_ack   <= 1'b0;
         b_ack   <= 1'b0;
         idx_err <= 1'b0;
         if (grant_a || grant_b) begin
            lat_idx <= grant_a ? a_idx : b_idx;
            lat_op  <= grant_a ? a_op  : b_op;
            lat_id  <= grant_b;
         end
         if (state == S_APPLY) begin
            a_ack     <= ~lat_id;
            b_ack     <= lat_id;
            idx_err   <= ~in_range;
            cmd_count <= cmd_count + CNT_W'(1);
            ptr       <= ~lat_id;
         end
      end
   end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter built with N=6 so that indices 6 and 7 are out of range.
// A transaction-level model predicts the outputs on every cycle. Directed
// sequences add literal checks at the points of interest.
module tb_jk_bank_arbiter;

   localparam int N     = 6;
   localparam int IDX_W = 3;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             a_valid, b_valid;
   logic [IDX_W-1:0] a_idx, b_idx;
   logic [1:0]       a_op, b_op;
   logic             a_ack, b_ack;
   logic [N-1:0]     q, qb;
   logic             busy, idx_err;
   logic [CNT_W-1:0] cmd_count;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 0;

   jk_bank_arbiter #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_idx     (a_idx),
      .a_op      (a_op),
      .a_ack     (a_ack),
      .b_valid   (b_valid),
      .b_idx     (b_idx),
      .b_op      (b_op),
      .b_ack     (b_ack),
      .q         (q),
      .qb        (qb),
      .busy      (busy),
      .idx_err   (idx_err),
      .cmd_count (cmd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // One command in flight at most. A command taken on one edge is applied on
   // the next edge, and its ack is visible for one cycle after that edge.
   logic [N-1:0]     m_q;
   logic [CNT_W-1:0] m_cnt;
   logic             m_aack, m_back, m_err, m_busy;
   bit               m_pend;
   int               m_turn;   // who wins a tie: 0 = A, 1 = B
   int               m_who, m_idx, m_op;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q = '0; m_cnt = '0; m_aack = 0; m_back = 0; m_err = 0; m_busy = 0;
         m_pend = 0; m_turn = 0; m_who = 0; m_idx = 0; m_op = 0;
      end else begin
         m_aack = 0; m_back = 0; m_err = 0;
         if (m_pend) begin
            if (m_idx < N) begin
               if (m_op == 1) m_q[m_idx] = 1'b0;
               else if (m_op == 2) m_q[m_idx] = 1'b1;
               else if (m_op == 3) m_q[m_idx] = ~m_q[m_idx];
            end else begin
               m_err = 1;
            end
            if (m_who == 0) m_aack = 1; else m_back = 1;
            m_cnt  = m_cnt + 1'b1;
            m_pend = 0;
            m_busy = 0;
         end else if (a_valid || b_valid) begin
            if (a_valid && b_valid) m_who = m_turn;
            else                    m_who = a_valid ? 0 : 1;
            m_idx  = (m_who == 0) ? int'(a_idx) : int'(b_idx);
            m_op   = (m_who == 0) ? int'(a_op)  : int'(b_op);
            m_turn = 1 - m_who;
            m_pend = 1;
            m_busy = 1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [N-1:0] m_qb;
         m_qb = ~m_q;
         chk("cyc_q",       32'(q),         32'(m_q));
         chk("cyc_qb",      32'(qb),        32'(m_qb));
         chk("cyc_busy",    32'(busy),      32'(m_busy));
         chk("cyc_a_ack",   32'(a_ack),     32'(m_aack));
         chk("cyc_b_ack",   32'(b_ack),     32'(m_back));
         chk("cyc_idx_err", 32'(idx_err),   32'(m_err));
         chk("cyc_count",   32'(cmd_count), 32'(m_cnt));
      end
   end

   // ---------------- directed stimulus ----------------
   // Present one command, hold it until its ack is seen, then drop it.
   // lat counts the falling edges from presentation to the edge where the ack is seen.
   task automatic send(input bit is_b, input logic [IDX_W-1:0] idx, input logic [1:0] op,
                       output int lat);
      bit got;
      got = 0;
      lat = 0;
      @(negedge clk);
      if (is_b) begin b_valid = 1; b_idx = idx; b_op = op; end
      else      begin a_valid = 1; a_idx = idx; a_op = op; end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (is_b ? b_ack : a_ack) begin
            got = 1;
            break;
         end
      end
      if (is_b) b_valid = 0; else a_valid = 0;
      if (!got) chk(is_b ? "ack_timeout_b" : "ack_timeout_a", 32'(got), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      logic [3:0] order;
      bit a_seen;
      bit got;

      rst_n = 0; a_valid = 0; b_valid = 0;
      a_idx = '0; b_idx = '0; a_op = '0; b_op = '0;
      #12 rst_n = 1;
      cmp_en = 1;

      // single-requester ops: set, toggle, clear of an already-clear bit
      send(0, 3'd3, 2'b10, lat);
      chk("single_set_q", 32'(q), 32'h08);
      chk("single_latency", 32'(lat), 32'd2);
      send(0, 3'd3, 2'b11, lat);
      chk("toggle_q", 32'(q), 32'h00);
      send(0, 3'd5, 2'b01, lat);
      chk("clear_q", 32'(q), 32'h00);
      send(0, 3'd4, 2'b10, lat);
      chk("set4_q", 32'(q), 32'h10);
      chk("count_4", 32'(cmd_count), 32'd4);

      // async reset in the middle of a low clock phase, checked before any edge
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("rst_q",     32'(q),         32'h00);
      chk("rst_qb",    32'(qb),        32'h3F);
      chk("rst_count", 32'(cmd_count), 32'd0);
      chk("rst_acks",  32'({a_ack, b_ack, busy, idx_err}), 32'd0);
      #10 rst_n = 1;

      // contention: both held valid for four grants
      @(negedge clk);
      a_valid = 1; a_idx = 3'd0; a_op = 2'b11;
      b_valid = 1; b_idx = 3'd1; b_op = 2'b11;
      n = 0; order = '0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (a_ack) n++;
         if (b_ack) begin order[n] = 1'b1; n++; end
      end
      a_valid = 0; b_valid = 0;
      chk("rr_grants", 32'(n), 32'd4);
      chk("rr_order_ABAB", 32'(order), 32'b1010);
      chk("rr_q", 32'(q), 32'h00);
      chk("rr_count", 32'(cmd_count), 32'd4);

      // out-of-range indices 7 and 6, then in-range 5
      send(1, 3'd7, 2'b10, lat);
      chk("oor7_err", 32'(idx_err), 32'd1);
      chk("oor7_q", 32'(q), 32'h00);
      chk("oor7_count", 32'(cmd_count), 32'd5);
      send(1, 3'd6, 2'b10, lat);
      chk("oor6_err", 32'(idx_err), 32'd1);
      chk("oor6_count", 32'(cmd_count), 32'd6);
      send(1, 3'd5, 2'b10, lat);
      chk("in5_err", 32'(idx_err), 32'd0);
      chk("in5_q", 32'(q), 32'h20);
      chk("in5_count", 32'(cmd_count), 32'd7);

      // 249 hold ops take the counter from 7 through 255 back to 0
      for (int i = 0; i < 249; i++) send(bit'(i % 2), IDX_W'(i % 6), 2'b00, lat);
      chk("wrap_count", 32'(cmd_count), 32'd0);
      chk("wrap_q", 32'(q), 32'h20);

      // reset during APPLY of A idx2 set; B is waiting through the reset
      @(negedge clk);
      a_valid = 1; a_idx = 3'd2; a_op = 2'b10;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      a_valid = 0;
      b_valid = 1; b_idx = 3'd1; b_op = 2'b10;
      #2 rst_n = 0;
      #1;
      chk("mid_rst_q", 32'(q), 32'h00);
      chk("mid_rst_aack", 32'(a_ack), 32'd0);
      @(negedge clk);
      chk("mid_rst_aack_edge", 32'(a_ack), 32'd0);
      #3 rst_n = 1;
      got = 0; a_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_ack) a_seen = 1;
         if (b_ack) begin got = 1; break; end
      end
      b_valid = 0;
      chk("post_rst_b_ack", 32'(got), 32'd1);
      chk("post_rst_no_a_ack", 32'(a_seen), 32'd0);
      chk("post_rst_q", 32'(q), 32'h02);
      chk("post_rst_count", 32'(cmd_count), 32'd1);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
